// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lc3_mem_arbiter
// Brief   : Two-port (CPU / loader) arbiter for the single-port LC-3 memory.
// Revision: 1.0 - initial release
// ============================================================================
module lc3_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int WAIT_CYCLES  = 1,
    parameter int CPU_PRIORITY = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              C_REQ,
    input  logic              C_WE,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    output logic              C_ACK,
    input  logic              L_REQ,
    input  logic              L_WE,
    input  logic [ADDR_W-1:0] L_ADDR,
    input  logic [DATA_W-1:0] L_WDATA,
    output logic              L_ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic              BUSY,
    output logic              GNT_ID,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);
    localparam logic       c_cpu_pri   = (CPU_PRIORITY != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_wait_cnt;
    logic       r_prefer_l;
    logic       w_any_req;
    logic       w_pick_l;

    // A lone requester always wins; the round-robin pointer only breaks ties.
    always_comb begin
        w_any_req = C_REQ | L_REQ;
        if (C_REQ && L_REQ) begin
            w_pick_l = c_cpu_pri ? 1'b0 : r_prefer_l;
        end else begin
            w_pick_l = L_REQ;
        end
    end

    // MEM_* registers double as the latched request, held steady through ACCESS.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_prefer_l <= 1'b0;
            C_ACK      <= 1'b0;
            L_ACK      <= 1'b0;
            RDATA      <= '0;
            BUSY       <= 1'b0;
            GNT_ID     <= 1'b0;
            MEM_EN     <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        GNT_ID     <= w_pick_l;
                        r_prefer_l <= ~w_pick_l;
                        MEM_EN     <= 1'b1;
                        MEM_WE     <= w_pick_l ? L_WE    : C_WE;
                        MEM_ADDR   <= w_pick_l ? L_ADDR  : C_ADDR;
                        MEM_WDATA  <= w_pick_l ? L_WDATA : C_WDATA;
                        r_wait_cnt <= c_wait_init;
                        BUSY       <= 1'b1;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_wait_cnt == 4'd0) begin
                        if (!MEM_WE) begin
                            RDATA <= MEM_RDATA;
                        end
                        MEM_EN    <= 1'b0;
                        MEM_WE    <= 1'b0;
                        MEM_ADDR  <= '0;
                        MEM_WDATA <= '0;
                        C_ACK     <= ~GNT_ID;
                        L_ACK     <= GNT_ID;
                        r_state   <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    C_ACK   <= 1'b0;
                    L_ACK   <= 1'b0;
                    BUSY    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_lc3_mem_arbiter
// Brief   : Bench for lc3_mem_arbiter; four configurations checked against a
//           transaction-timestamp reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lc3_mem_arbiter;

    localparam int NI = 4;

    logic                 clk;
    logic                 rst_n;
    logic [NI-1:0]        c_req, c_we, c_ack, l_req, l_we, l_ack;
    logic [NI-1:0]        busy, gnt_id, mem_en, mem_we;
    logic [NI-1:0][15:0]  c_addr, c_wdata, l_addr, l_wdata;
    logic [NI-1:0][15:0]  rdata, mem_addr, mem_wdata, mem_rdata;

    // Instance configs: 0 = RR/W1, 1 = CPU priority/W1, 2 = RR/W0, 3 = RR/W15
    for (genvar g = 0; g < NI; g++) begin : g_dut
        lc3_mem_arbiter #(
            .ADDR_W      (16),
            .DATA_W      (16),
            .WAIT_CYCLES ((g == 2) ? 0 : ((g == 3) ? 15 : 1)),
            .CPU_PRIORITY((g == 1) ? 1 : 0)
        ) u_dut (
            .CLK      (clk),
            .RESET_N  (rst_n),
            .C_REQ    (c_req[g]),
            .C_WE     (c_we[g]),
            .C_ADDR   (c_addr[g]),
            .C_WDATA  (c_wdata[g]),
            .C_ACK    (c_ack[g]),
            .L_REQ    (l_req[g]),
            .L_WE     (l_we[g]),
            .L_ADDR   (l_addr[g]),
            .L_WDATA  (l_wdata[g]),
            .L_ACK    (l_ack[g]),
            .RDATA    (rdata[g]),
            .BUSY     (busy[g]),
            .GNT_ID   (gnt_id[g]),
            .MEM_EN   (mem_en[g]),
            .MEM_WE   (mem_we[g]),
            .MEM_ADDR (mem_addr[g]),
            .MEM_WDATA(mem_wdata[g]),
            .MEM_RDATA(mem_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] key;
        logic [15:0] exp_rd;
        int          lat;
        int          en;
    } vec_t;

    int          n_tests, n_fail, cyc;
    logic [15:0] rd_key;

    // Reference model: each transaction is a start cycle s plus latched fields.
    int          m_start [NI];
    bit          m_gnt   [NI];
    bit          m_gid   [NI];
    bit          m_pref_l[NI];
    bit          m_we    [NI];
    logic [15:0] m_addr  [NI];
    logic [15:0] m_wdata [NI];
    logic [15:0] m_rdata [NI];

    bit          wait_q  [NI][2];
    bit          persist [NI][2];
    bit          we_q    [NI][2];
    logic [15:0] addr_q  [NI][2];
    logic [15:0] wd_q    [NI][2];
    int          ack_cnt [NI];
    bit          ack_seq [NI][64];

    function automatic int wait_of(input int k);
        if (k == 2) return 0;
        if (k == 3) return 15;
        return 1;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s inst%0d cyc%0d: got %0h, expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_start[k]  = -100;
            m_gnt[k]    = 1'b0;
            m_gid[k]    = 1'b0;
            m_pref_l[k] = 1'b0;
            m_we[k]     = 1'b0;
            m_addr[k]   = '0;
            m_wdata[k]  = '0;
            m_rdata[k]  = '0;
            ack_cnt[k]  = 0;
            c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
            l_req[k] = 1'b0; l_we[k] = 1'b0; l_addr[k] = '0; l_wdata[k] = '0;
            mem_rdata[k] = '0;
            for (int p = 0; p < 2; p++) begin
                wait_q[k][p]  = 1'b0;
                persist[k][p] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int k, input int p, input bit we, input logic [15:0] a, input logic [15:0] d);
        wait_q[k][p] = 1'b1;
        we_q[k][p]   = we;
        addr_q[k][p] = a;
        wd_q[k][p]   = d;
    endtask

    // One cycle: check outputs, drive requesters and memory, advance model, clock.
    task automatic step(input bit rnd);
        for (int k = 0; k < NI; k++) begin
            int w, s;
            bit acc, done, win;
            w    = wait_of(k);
            s    = m_start[k];
            acc  = (cyc >= s + 1) && (cyc <= s + 1 + w);
            done = (cyc == s + 2 + w);
            chk("mem_en", k, 32'(mem_en[k]), 32'(acc));
            chk("mem_we", k, 32'(mem_we[k]), 32'(acc && m_we[k]));
            if (acc) begin
                chk("mem_addr", k, 32'(mem_addr[k]), 32'(m_addr[k]));
                chk("mem_wdata", k, 32'(mem_wdata[k]), 32'(m_wdata[k]));
            end
            chk("c_ack", k, 32'(c_ack[k]), 32'(done && !m_gnt[k]));
            chk("l_ack", k, 32'(l_ack[k]), 32'(done && m_gnt[k]));
            chk("ack_excl", k, 32'(c_ack[k] & l_ack[k]), 32'd0);
            chk("busy", k, 32'(busy[k]), 32'(acc || done));
            chk("gnt_id", k, 32'(gnt_id[k]), 32'(m_gid[k]));
            chk("rdata", k, 32'(rdata[k]), 32'(m_rdata[k]));
            if (c_ack[k] || l_ack[k]) begin
                if (ack_cnt[k] < 64) ack_seq[k][ack_cnt[k]] = l_ack[k];
                ack_cnt[k]++;
            end

            for (int p = 0; p < 2; p++) begin
                bit          insvc, rq, rwe;
                logic [15:0] ra, rd;
                insvc = (int'(m_gnt[k]) == p) && (cyc >= s + 1) && (cyc <= s + 2 + w);
                if (!wait_q[k][p] && !insvc && (persist[k][p] || (rnd && $urandom_range(0, 3) == 0)))
                    issue(k, p, 1'($urandom), 16'($urandom), 16'($urandom));
                if (wait_q[k][p]) begin
                    rq = 1'b1; rwe = we_q[k][p]; ra = addr_q[k][p]; rd = wd_q[k][p];
                end else begin
                    rq  = insvc ? 1'($urandom) : 1'b0;
                    rwe = 1'($urandom); ra = 16'($urandom); rd = 16'($urandom);
                end
                if (p == 0) begin
                    c_req[k] = rq; c_we[k] = rwe; c_addr[k] = ra; c_wdata[k] = rd;
                end else begin
                    l_req[k] = rq; l_we[k] = rwe; l_addr[k] = ra; l_wdata[k] = rd;
                end
            end

            mem_rdata[k] = (cyc == s + 1 + w) ? (m_addr[k] ^ rd_key) : 16'($urandom);

            if (rst_n) begin
                if (cyc == s + 1 + w && !m_we[k]) m_rdata[k] = m_addr[k] ^ rd_key;
                if (cyc > s + 2 + w && (c_req[k] || l_req[k])) begin
                    win = l_req[k] && (!c_req[k] || (k != 1 && m_pref_l[k]));
                    m_start[k]  = cyc;
                    m_gnt[k]    = win;
                    m_gid[k]    = win;
                    m_pref_l[k] = !win;
                    m_we[k]     = win ? l_we[k]    : c_we[k];
                    m_addr[k]   = win ? l_addr[k]  : c_addr[k];
                    m_wdata[k]  = win ? l_wdata[k] : c_wdata[k];
                    wait_q[k][int'(win)] = 1'b0;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int k, n, lat, en_cnt, we_cnt, addr_ok, wrong;
        logic [15:0] rd_at_ack;
        k = v.inst; n = cyc; lat = -1; en_cnt = 0; we_cnt = 0; addr_ok = 0; wrong = 0;
        rd_at_ack = '0;
        rd_key = v.key;
        issue(k, int'(v.port), v.we, v.addr, v.wdata);
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (mem_en[k]) en_cnt++;
            if (mem_we[k]) we_cnt++;
            if (mem_en[k] && mem_addr[k] == v.addr) addr_ok++;
            if (v.port ? c_ack[k] : l_ack[k]) wrong++;
            if (v.port ? l_ack[k] : c_ack[k]) begin
                lat = cyc - n;
                rd_at_ack = rdata[k];
            end
            step(1'b0);
        end
        chk("vec_latency", k, 32'(lat), 32'(v.lat));
        chk("vec_rdata", k, 32'(rd_at_ack), 32'(v.exp_rd));
        chk("vec_en_cycles", k, 32'(en_cnt), 32'(v.en));
        chk("vec_we_cycles", k, 32'(we_cnt), v.we ? 32'(v.en) : 32'd0);
        chk("vec_addr_held", k, 32'(addr_ok), 32'(v.en));
        chk("vec_other_ack", k, 32'(wrong), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0);
    endtask

    vec_t vecs[6];

    initial begin
        int i, base;
        vecs[0] = '{0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h2234, 16'h1234, 3, 2};
        vecs[1] = '{0, 1'b1, 1'b1, 16'h3001, 16'hBEEF, 16'h0000, 16'h1234, 3, 2};
        vecs[2] = '{2, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h00EA, 16'h00AA, 2, 1};
        vecs[3] = '{3, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'hEDCB, 17, 16};
        vecs[4] = '{3, 1'b1, 1'b1, 16'h0005, 16'h5555, 16'h0000, 16'hEDCB, 17, 16};
        vecs[5] = '{1, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0F0F, 16'h0FF0, 3, 2};

        n_tests = 0; n_fail = 0; cyc = 0;
        rd_key  = 16'h6C3A;
        rst_n   = 1'b0;
        model_reset();
        @(negedge clk);
        for (int j = 0; j < 3; j++) step(1'b0);

        // Both ports requesting continuously from reset on RR and CPU-priority instances
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                persist[k][p] = 1'b1;
                issue(k, p, 1'($urandom), 16'($urandom), 16'($urandom));
            end
        rst_n = 1'b1;
        i = 0;
        while ((ack_cnt[0] < 4 || ack_cnt[1] < 4) && i < 80) begin
            step(1'b0);
            i++;
        end
        chk("tie_acks_seen", 0, 32'(ack_cnt[0] >= 4 && ack_cnt[1] >= 4), 32'd1);
        for (int j = 0; j < 4; j++) begin
            chk("rr_order", 0, 32'(ack_seq[0][j]), 32'(j % 2));
            chk("pri_order", 1, 32'(ack_seq[1][j]), 32'd0);
        end

        // CPU goes quiet for one IDLE cycle right after its ACK: loader must win
        base = ack_cnt[1];
        i = 0;
        while (ack_cnt[1] == base && i < 40) begin step(1'b0); i++; end
        persist[1][0] = 1'b0;
        base = ack_cnt[1];
        i = 0;
        while (ack_cnt[1] == base && i < 40) begin step(1'b0); i++; end
        chk("pri_l_acked", 1, 32'(ack_cnt[1] > base), 32'd1);
        chk("pri_l_served", 1, 32'(ack_seq[1][base]), 32'd1);
        persist[0][0] = 1'b0; persist[0][1] = 1'b0; persist[1][1] = 1'b0;
        for (int j = 0; j < 40; j++) step(1'b0);

        foreach (vecs[j]) run_vec(vecs[j]);

        // Asynchronous reset in the middle of a long access
        rd_key = 16'h6C3A;
        issue(3, 0, 1'b0, 16'h0100, 16'h0000);
        for (int j = 0; j < 6; j++) step(1'b0);
        chk("pre_rst_en", 3, 32'(mem_en[3]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_mem_en", k, 32'(mem_en[k]), 32'd0);
            chk("rst_busy", k, 32'(busy[k]), 32'd0);
            chk("rst_acks", k, 32'({c_ack[k], l_ack[k]}), 32'd0);
            chk("rst_rdata", k, 32'(rdata[k]), 32'd0);
        end
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int j = 0; j < 2; j++) step(1'b0);
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) step(1'b0);

        for (int j = 0; j < 3000; j++) step(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
